// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// Instruction feeder: steps through a small {opcode, op1, op2} program memory, issues one
// word at a time to the core, waits out its two-register latency and captures result/flags.
module instr_sequencer #(
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [23:0]   prog_wdata,
    input  logic          start,
    output logic [7:0]    opcode_out,
    output logic [7:0]    operand1_out,
    output logic [7:0]    operand2_out,
    input  logic [7:0]    proc_result,
    input  logic [7:0]    proc_flags,
    output logic          res_valid,
    output logic [7:0]    res_data,
    output logic [7:0]    res_flags,
    output logic [AW-1:0] res_pc,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT1   = 3'd2,
        S_WAIT2   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          done_q, done_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    operand1_q, operand1_d;
    logic [7:0]    operand2_q, operand2_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;
    logic [7:0]    res_flags_q, res_flags_d;
    logic [AW-1:0] res_pc_q, res_pc_d;

    logic [23:0]   mem [DEPTH];
    logic [23:0]   fetch_word;
    logic          busy_w;
    logic          mem_we;

    assign busy_w     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign mem_we     = prog_we && !busy_w;
    assign fetch_word = mem[pc_q];

    // Program memory has no reset: contents survive an aborted run.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            done_q      <= 1'b0;
            opcode_q    <= '0;
            operand1_q  <= '0;
            operand2_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            done_q      <= done_d;
            opcode_q    <= opcode_d;
            operand1_q  <= operand1_d;
            operand2_q  <= operand2_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_pc_q    <= res_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        done_d      = done_q;
        opcode_d    = opcode_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_pc_d    = res_pc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    done_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A halt word is never issued, so the core keeps its last operands.
                if (fetch_word[23:16] == HALT_OP) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    opcode_d   = fetch_word[23:16];
                    operand1_d = fetch_word[15:8];
                    operand2_d = fetch_word[7:0];
                    state_d    = S_WAIT1;
                end
            end
            S_WAIT1: state_d = S_WAIT2;
            S_WAIT2: state_d = S_CAPTURE;
            S_CAPTURE: begin
                res_data_d  = proc_result;
                res_flags_d = proc_flags;
                res_pc_d    = pc_q;
                res_valid_d = 1'b1;
                if (pc_q == AW'(DEPTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign opcode_out   = opcode_q;
    assign operand1_out = operand1_q;
    assign operand2_out = operand2_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_flags    = res_flags_q;
    assign res_pc       = res_pc_q;
    assign pc           = pc_q;
    assign busy         = busy_w;
    assign done         = done_q;

endmodule
